// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, read owner, latency counter width.
// Imported by rr_arb2 and dmem_arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_e;

  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-input picker for the data memory arbiter: one-hot grant, bit 0 = CPU.
// With DMEM_ARB_CPU_PRIO_EN defined it is a fixed CPU-first pick, no pointer.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       en_i,
`ifndef DMEM_ARB_CPU_PRIO_EN
  input  owner_e     ptr_i,
`endif
  output logic [1:0] gnt_o
);

  // Pick one requester; contention resolved by pointer or fixed priority
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
`ifdef DMEM_ARB_CPU_PRIO_EN
        2'b11:   gnt_o = 2'b01;
`else
        2'b11: begin
          if (ptr_i == OWN_DBG) gnt_o = 2'b10;
          else                  gnt_o = 2'b01;
        end
`endif
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/debug arbiter in front of the single-port data memory.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           gnt;
`ifndef DMEM_ARB_CPU_PRIO_EN
  owner_e               ptr_q, ptr_d;
`endif

  // Grants only in IDLE and never while reset is held
  rr_arb2 u_arb (
    .req_i ({dbg_req_i, cpu_req_i}),
    .en_i  ((state_q == IDLE) && rst_ni),
`ifndef DMEM_ARB_CPU_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (gnt)
  );

  assign busy_o = (state_q == WAIT);

  // Next state, memory mux and read-data routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
`ifndef DMEM_ARB_CPU_PRIO_EN
    ptr_d        = ptr_q;
`endif
    cpu_gnt_o    = gnt[0];
    dbg_gnt_o    = gnt[1];
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    dbg_rvalid_o = 1'b0;
    dbg_rdata_o  = '0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt[0]: begin
            mem_req_o   = 1'b1;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
          end
          gnt[1]: begin
            mem_req_o   = 1'b1;
            mem_we_o    = dbg_we_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
          end
          default: ;
        endcase
        if (mem_req_o) begin
`ifndef DMEM_ARB_CPU_PRIO_EN
          if (gnt[0]) ptr_d = OWN_DBG;
          else        ptr_d = OWN_CPU;
`endif
          if (!mem_we_o) begin
            state_d = WAIT;
            cnt_d   = LAT_INIT;
            if (gnt[1]) owner_d = OWN_DBG;
            else        owner_d = OWN_CPU;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (owner_q == OWN_DBG) begin
            dbg_rvalid_o = 1'b1;
            dbg_rdata_o  = mem_rdata_i;
          end else begin
            cpu_rvalid_o = 1'b1;
            cpu_rdata_o  = mem_rdata_i;
          end
        end
      end
    endcase
  end

  // State, owner, latency counter and priority pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      cnt_q   <= '0;
`ifndef DMEM_ARB_CPU_PRIO_EN
      ptr_q   <= OWN_CPU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`ifndef DMEM_ARB_CPU_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances on shared stimulus.
// Honors DMEM_ARB_CPU_PRIO_EN for the contention expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic        c1_gnt, c1_rv, d1_gnt, d1_rv, m1_req, m1_we, busy1;
  logic [31:0] c1_rd, d1_rd, m1_addr, m1_wd, m1_rdata;
  logic        c3_gnt, c3_rv, d3_gnt, d3_rv, m3_req, m3_we, busy3;
  logic [31:0] c3_rd, d3_rd, m3_addr, m3_wd, m3_rdata;

  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(c1_gnt), .cpu_rvalid_o(c1_rv), .cpu_rdata_o(c1_rd),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(d1_gnt), .dbg_rvalid_o(d1_rv), .dbg_rdata_o(d1_rd),
    .mem_req_o(m1_req), .mem_we_o(m1_we),
    .mem_addr_o(m1_addr), .mem_wdata_o(m1_wd),
    .mem_rdata_i(m1_rdata), .busy_o(busy1)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(c3_gnt), .cpu_rvalid_o(c3_rv), .cpu_rdata_o(c3_rd),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(d3_gnt), .dbg_rvalid_o(d3_rv), .dbg_rdata_o(d3_rd),
    .mem_req_o(m3_req), .mem_we_o(m3_we),
    .mem_addr_o(m3_addr), .mem_wdata_o(m3_wd),
    .mem_rdata_i(m3_rdata), .busy_o(busy3)
  );

  // Memory models: word-indexed storage with MEM_LAT read pipelines
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] p1;
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (m1_req && m1_we) mem1[m1_addr[7:2]] <= m1_wd;
    if (m1_req && !m1_we) p1 <= mem1[m1_addr[7:2]];
    if (m3_req && m3_we) mem3[m3_addr[7:2]] <= m3_wd;
    if (m3_req && !m3_we) p3[0] <= mem3[m3_addr[7:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign m1_rdata = p1;
  assign m3_rdata = p3[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected read responses queued at grant
  typedef struct {
    logic        dbg;
    logic [31:0] data;
  } rsp_t;

  rsp_t q1[$];
  rsp_t q3[$];

  always @(negedge clk) begin
    rsp_t r;
    if (!rst_ni) begin
      q1.delete();
      q3.delete();
    end else begin
      if (c1_rv || d1_rv) begin
        if (q1.size() == 0) begin
          chk("rsp1_unexpected", {30'd0, d1_rv, c1_rv}, 32'd0);
        end else begin
          r = q1.pop_front();
          chk("rsp1_owner", {31'd0, d1_rv}, {31'd0, r.dbg});
          chk("rsp1_single", {31'd0, c1_rv & d1_rv}, 32'd0);
          chk("rsp1_data", r.dbg ? d1_rd : c1_rd, r.data);
          chk("rsp1_other0", r.dbg ? c1_rd : d1_rd, 32'd0);
        end
      end
      if (c3_rv || d3_rv) begin
        if (q3.size() == 0) begin
          chk("rsp3_unexpected", {30'd0, d3_rv, c3_rv}, 32'd0);
        end else begin
          r = q3.pop_front();
          chk("rsp3_owner", {31'd0, d3_rv}, {31'd0, r.dbg});
          chk("rsp3_single", {31'd0, c3_rv & d3_rv}, 32'd0);
          chk("rsp3_data", r.dbg ? d3_rd : c3_rd, r.data);
          chk("rsp3_other0", r.dbg ? c3_rd : d3_rd, 32'd0);
        end
      end
      if (m1_req && !m1_we)
        q1.push_back('{dbg: d1_gnt, data: mem1[m1_addr[7:2]]});
      if (m3_req && !m3_we)
        q3.push_back('{dbg: d3_gnt, data: mem3[m3_addr[7:2]]});
    end
  end

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        ecg, edg, emw;
    logic [31:0] ea, ed;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(
    input logic cr, input logic cw,
    input logic [31:0] ca, input logic [31:0] cd,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd,
    input logic ecg, input logic edg, input logic emw,
    input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ecg = ecg; v.edg = edg; v.emw = emw;
    v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic drive(input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  logic cf;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    p1 = 32'd0;
    for (int i = 0; i < 3; i++) p3[i] = 32'd0;

    // Reset values, with a CPU request held during reset
    rst_ni = 1'b0;
    drive(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rst_cpu_gnt", {31'd0, c1_gnt}, 32'd0);
    chk("rst_dbg_gnt", {31'd0, d1_gnt}, 32'd0);
    chk("rst_mem_req", {31'd0, m1_req}, 32'd0);
    chk("rst_mem_we", {31'd0, m1_we}, 32'd0);
    chk("rst_busy", {31'd0, busy3}, 32'd0);
    chk("rst_rvalid", {30'd0, c3_rv, d3_rv}, 32'd0);
    do_reset();

    // Table: single writes, then sustained contention
    tbl[0] = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,
                1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[1] = mk(1'b1, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0,
                1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
    tbl[2] = mk(1'b1, 1'b1, 32'd96, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0,
                1'b1, 1'b0, 1'b1, 32'd96, 32'd8);
    tbl[3] = mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd40, 32'd5,
                1'b0, 1'b1, 1'b1, 32'd40, 32'd5);
    for (int k = 4; k < 10; k++) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      cf = 1'b1;
`else
      cf = (k % 2 == 0);
`endif
      tbl[k] = mk(1'b1, 1'b1, 32'd200, 32'hA, 1'b1, 1'b1, 32'd300, 32'hB,
                  cf, !cf, 1'b1,
                  cf ? 32'd200 : 32'd300, cf ? 32'hA : 32'hB);
    end
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
            tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", i), {31'd0, c1_gnt}, {31'd0, tbl[i].ecg});
      chk($sformatf("v%0d_dbg_gnt", i), {31'd0, d1_gnt}, {31'd0, tbl[i].edg});
      chk($sformatf("v%0d_mem_req", i), {31'd0, m1_req},
          {31'd0, tbl[i].ecg | tbl[i].edg});
      chk($sformatf("v%0d_mem_we", i), {31'd0, m1_we}, {31'd0, tbl[i].emw});
      if (tbl[i].ecg || tbl[i].edg) begin
        chk($sformatf("v%0d_addr", i), m1_addr, tbl[i].ea);
        chk($sformatf("v%0d_wdata", i), m1_wd, tbl[i].ed);
      end
      next();
    end
    idle();
    next();

    // MEM_LAT=1: CPU read while debug keeps requesting
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd96, 32'h12345678);
    next();
    drive(1'b1, 1'b0, 32'd96, 32'd0, 1'b1, 1'b0, 32'd40, 32'd0);
    @(negedge clk);
    chk("l1_t0_cpu_gnt", {31'd0, c1_gnt}, 32'd1);
    chk("l1_t0_dbg_gnt", {31'd0, d1_gnt}, 32'd0);
    chk("l1_t0_mem_req", {31'd0, m1_req}, 32'd1);
    chk("l1_t0_mem_we", {31'd0, m1_we}, 32'd0);
    chk("l1_t0_addr", m1_addr, 32'd96);
    next();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("l1_t1_cpu_rv", {31'd0, c1_rv}, 32'd1);
    chk("l1_t1_cpu_rd", c1_rd, 32'h12345678);
    chk("l1_t1_dbg_rv", {31'd0, d1_rv}, 32'd0);
    chk("l1_t1_dbg_gnt", {31'd0, d1_gnt}, 32'd0);
    chk("l1_t1_busy", {31'd0, busy1}, 32'd1);
    next();
    @(negedge clk);
    chk("l1_t2_dbg_gnt", {31'd0, d1_gnt}, 32'd1);
    chk("l1_t2_dbg_rv", {31'd0, d1_rv}, 32'd0);
    next();
    idle();
    repeat (4) next();

    // MEM_LAT=3: debug read, then CPU write waits for IDLE
    do_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd96, 32'd0);
    @(negedge clk);
    chk("l3_t0_dbg_gnt", {31'd0, d3_gnt}, 32'd1);
    chk("l3_t0_mem_req", {31'd0, m3_req}, 32'd1);
    chk("l3_t0_busy", {31'd0, busy3}, 32'd0);
    next();
    drive(1'b1, 1'b1, 32'd500, 32'd9, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("l3_t%0d_busy", k), {31'd0, busy3}, 32'd1);
      chk($sformatf("l3_t%0d_dbg_rv", k), {31'd0, d3_rv},
          {31'd0, k == 3});
      chk($sformatf("l3_t%0d_cpu_gnt", k), {31'd0, c3_gnt}, 32'd0);
      chk($sformatf("l3_t%0d_mem_req", k), {31'd0, m3_req}, 32'd0);
      if (k == 3) chk("l3_t3_dbg_rd", d3_rd, 32'h12345678);
      next();
    end
    @(negedge clk);
    chk("l3_t4_cpu_gnt", {31'd0, c3_gnt}, 32'd1);
    chk("l3_t4_busy", {31'd0, busy3}, 32'd0);
    chk("l3_t4_mem_we", {31'd0, m3_we}, 32'd1);
    next();
    idle();
    repeat (2) next();

    // Reset in the middle of a MEM_LAT=3 read
    do_reset();
    drive(1'b1, 1'b0, 32'd200, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    next();
    idle();
    next();
    chk("mr_busy_before", {31'd0, busy3}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mr_busy", {31'd0, busy3}, 32'd0);
    chk("mr_rvalid", {30'd0, c3_rv, d3_rv}, 32'd0);
    chk("mr_mem_req", {31'd0, m3_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    drive(1'b1, 1'b1, 32'd8, 32'd1, 1'b1, 1'b1, 32'd12, 32'd2);
    @(negedge clk);
    chk("mr_first_cpu_gnt", {31'd0, c3_gnt}, 32'd1);
    chk("mr_first_dbg_gnt", {31'd0, d3_gnt}, 32'd0);
    next();
    @(negedge clk);
`ifdef DMEM_ARB_CPU_PRIO_EN
    chk("mr_second_cpu_gnt", {31'd0, c3_gnt}, 32'd1);
`else
    chk("mr_second_dbg_gnt", {31'd0, d3_gnt}, 32'd1);
`endif
    next();
    idle();
    repeat (6) next();

    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
